encoder_sys: RTL and testbench

ENCODER_SYS -- requirements
Module: encoder_sys

---
 rtl/encoder_sys_if.sv | 39 +++
 rtl/encoder_sys.sv | 146 ++++++++++++++
 tb/tb_encoder_sys.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/encoder_sys_if.sv
// Frame-in / symbol-out handshake bundle for the convolutional encoder.
// master drives frames and consumes symbols; slave is the encoder.
interface encoder_sys_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        choose_constraint_length;
  logic [1:0]        encoded_bits;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;

  modport master (
    output in_data,
    output in_valid,
    output choose_constraint_length,
    output out_ready,
    input  in_ready,
    input  encoded_bits,
    input  out_valid,
    input  out_last,
    input  busy
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  choose_constraint_length,
    input  out_ready,
    output in_ready,
    output encoded_bits,
    output out_valid,
    output out_last,
    output busy
  );
endinterface

// File: rtl/encoder_sys.sv
// Rate-1/2 feedforward convolutional encoder, K selectable 3..6,
// zero-tail terminated frames, registered valid/ready symbol output.
module encoder_sys #(
  parameter int DATA_W = 16
) (
  input logic           clk,
  input logic           rst_n,
  encoder_sys_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ENCODE,
    TAIL
  } state_e;

  localparam int CW = $clog2(DATA_W + 6);

  state_e            state_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic [2:0]        k_q;
  logic [2:0]        k_in_d;
  logic [4:0]        sr_q;
  logic [4:0]        sr_d;
  logic [4:0]        sr_mask;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [CW-1:0]     last_idx;
  logic [1:0]        enc_q;
  logic [1:0]        enc_nxt;
  logic [1:0]        enc_acc;
  logic              vld_q;
  logic              last_q;
  logic              rdy_q;
  logic              busy_q;
  logic              hs;
  logic              acc;

  // sr[0] is d1 (newest), sr[4] is d5 (oldest)
  function automatic logic [1:0] enc(
    input logic       u,
    input logic [4:0] sr,
    input logic [2:0] k
  );
    logic [5:0] v6;
    logic [5:0] v;
    logic [5:0] g0;
    logic [5:0] g1;
    v6 = {u, sr[0], sr[1], sr[2], sr[3], sr[4]};
    v  = v6 >> (3'd6 - k);
    unique case (k)
      3'd3:    begin g0 = 6'o07; g1 = 6'o05; end
      3'd4:    begin g0 = 6'o17; g1 = 6'o15; end
      3'd5:    begin g0 = 6'o35; g1 = 6'o23; end
      default: begin g0 = 6'o75; g1 = 6'o53; end
    endcase
    return {^(g0 & v), ^(g1 & v)};
  endfunction

  always_comb begin
    k_in_d = bus.choose_constraint_length;
    unique case (1'b1)
      (bus.choose_constraint_length < 3'd3): k_in_d = 3'd3;
      (bus.choose_constraint_length == 3'd7): k_in_d = 3'd6;
      default: k_in_d = bus.choose_constraint_length;
    endcase
    unique case (k_q)
      3'd3:    sr_mask = 5'b00011;
      3'd4:    sr_mask = 5'b00111;
      3'd5:    sr_mask = 5'b01111;
      default: sr_mask = 5'b11111;
    endcase
    hs       = vld_q & bus.out_ready;
    acc      = rdy_q & bus.in_valid;
    data_d   = {data_q[DATA_W-2:0], 1'b0};
    sr_d     = {sr_q[3:0], data_q[DATA_W-1]} & sr_mask;
    cnt_d    = cnt_q + 1'b1;
    last_idx = CW'(DATA_W - 2) + CW'(k_q);
    enc_nxt  = enc(data_d[DATA_W-1], sr_d, k_q);
    enc_acc  = enc(bus.in_data[DATA_W-1], 5'd0, k_in_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      k_q     <= 3'd3;
      sr_q    <= '0;
      cnt_q   <= '0;
      enc_q   <= 2'b00;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc) begin
            data_q  <= bus.in_data;
            k_q     <= k_in_d;
            sr_q    <= '0;
            cnt_q   <= '0;
            enc_q   <= enc_acc;
            vld_q   <= 1'b1;
            last_q  <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ENCODE;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        ENCODE, TAIL: begin
          if (hs) begin
            if (last_q) begin
              state_q <= IDLE;
              sr_q    <= '0;
              cnt_q   <= '0;
              enc_q   <= 2'b00;
              vld_q   <= 1'b0;
              last_q  <= 1'b0;
              rdy_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              data_q  <= data_d;
              sr_q    <= sr_d;
              cnt_q   <= cnt_d;
              enc_q   <= enc_nxt;
              last_q  <= (cnt_d == last_idx);
              state_q <= (cnt_d >= CW'(DATA_W)) ? TAIL : ENCODE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = rdy_q;
  assign bus.encoded_bits = enc_q;
  assign bus.out_valid    = vld_q;
  assign bus.out_last     = last_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_encoder_sys.sv
// Randomized bench for encoder_sys against a convolution model
// built directly from generator polynomials and the zero-tail frame.
module tb_encoder_sys;

  localparam int DW = 16;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic [1:0] exp_q[$];

  encoder_sys_if #(.DATA_W(DW)) bus ();

  encoder_sys #(.DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void build(input logic [15:0] d,
                                input logic [2:0] kin);
    int k;
    logic [5:0] g0;
    logic [5:0] g1;
    bit b[$];
    bit s0;
    bit s1;
    k = (kin < 3) ? 3 : ((kin == 7) ? 6 : int'(kin));
    case (k)
      3: begin g0 = 6'o07; g1 = 6'o05; end
      4: begin g0 = 6'o17; g1 = 6'o15; end
      5: begin g0 = 6'o35; g1 = 6'o23; end
      default: begin g0 = 6'o75; g1 = 6'o53; end
    endcase
    exp_q.delete();
    for (int i = 0; i < 16; i++) b.push_back(d[15-i]);
    for (int i = 0; i < k - 1; i++) b.push_back(1'b0);
    for (int i = 0; i < b.size(); i++) begin
      s0 = 0;
      s1 = 0;
      for (int t = 0; t < k; t++) begin
        if (i - t >= 0) begin
          s0 ^= g0[k-1-t] & b[i-t];
          s1 ^= g1[k-1-t] & b[i-t];
        end
      end
      exp_q.push_back({s0, s1});
    end
  endfunction

  // mode 1 = random out_ready; abort_at >= 0 asserts reset at that symbol
  task automatic run_frame(input logic [15:0] d, input logic [2:0] kin,
                           input int mode, input int stall_at,
                           input int stall_len, input bit noise,
                           input int abort_at, input string tag);
    int n;
    int idx;
    int cyc;
    int stalled;
    logic exp_last;
    build(d, kin);
    n = exp_q.size();
    @(negedge clk);
    cyc = 0;
    while (bus.in_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_timeout in_ready=%b want 1", tag, bus.in_ready);
      return;
    end
    bus.in_data = d;
    bus.choose_constraint_length = kin;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data = 16'($urandom);
    bus.choose_constraint_length = 3'($urandom);
    idx = 0;
    cyc = 0;
    stalled = 0;
    while (idx < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      exp_last = (idx == n - 1);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.encoded_bits !== exp_q[idx] ||
          bus.out_last !== exp_last || bus.in_ready !== 1'b0 ||
          bus.busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s sym%0d got v=%b bits=%b last=%b rdy=%b busy=%b want v=1 bits=%b last=%b rdy=0 busy=1",
                 tag, idx, bus.out_valid, bus.encoded_bits, bus.out_last,
                 bus.in_ready, bus.busy, exp_q[idx], exp_last);
      end
      if (idx == abort_at) begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        return;
      end
      if (mode == 1) begin
        bus.out_ready = ($urandom % 4) != 0;
      end else if (idx == stall_at && stalled < stall_len) begin
        bus.out_ready = 1'b0;
        stalled++;
      end else begin
        bus.out_ready = 1'b1;
      end
      bus.in_valid = noise ? 1'($urandom % 2) : 1'b0;
      bus.in_data = 16'($urandom);
      if (bus.out_ready && idx == n - 1) bus.in_valid = 1'b0;
      if (bus.out_ready) idx++;
    end
    if (idx < n) begin
      vectors++;
      miscompares++;
      $display("FAIL %s frame_timeout got %0d symbols want %0d", tag, idx, n);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
        bus.encoded_bits !== 2'b00 || bus.busy !== 1'b0 ||
        bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s frame_end got v=%b last=%b bits=%b busy=%b rdy=%b want 0 0 00 0 1",
               tag, bus.out_valid, bus.out_last, bus.encoded_bits,
               bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.choose_constraint_length = 3'd3;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
        bus.encoded_bits !== 2'b00 || bus.busy !== 1'b0 ||
        bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state got v=%b last=%b bits=%b busy=%b rdy=%b want all 0",
               bus.out_valid, bus.out_last, bus.encoded_bits,
               bus.busy, bus.in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release got rdy=%b v=%b want rdy=1 v=0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_impulse_k3();
    run_frame(16'h8000, 3'd3, 0, -1, 0, 0, -1, "impulse_k3");
  endtask

  task automatic test_ones_k3();
    run_frame(16'hFFFF, 3'd3, 0, -1, 0, 0, -1, "ones_k3");
  endtask

  task automatic test_impulse_k6();
    run_frame(16'h8000, 3'd6, 0, -1, 0, 0, -1, "impulse_k6");
  endtask

  task automatic test_backpressure();
    run_frame(16'h8000, 3'd3, 0, 1, 5, 0, -1, "stall_k3");
  endtask

  task automatic test_clamp_busy();
    run_frame(16'h8000, 3'd7, 0, -1, 0, 1, -1, "clamp_k7");
    run_frame(16'hA5C3, 3'd1, 0, 4, 3, 1, -1, "clamp_k1");
  endtask

  task automatic test_reset_midframe();
    run_frame(16'h8000, 3'd3, 0, -1, 0, 0, 7, "abort");
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.in_ready !== 1'b0 || bus.encoded_bits !== 2'b00 ||
        bus.out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_reset got v=%b busy=%b rdy=%b bits=%b last=%b want 0 0 0 00 0",
               bus.out_valid, bus.busy, bus.in_ready,
               bus.encoded_bits, bus.out_last);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_release got rdy=%b v=%b want rdy=1 v=0",
               bus.in_ready, bus.out_valid);
    end
    run_frame(16'h8000, 3'd3, 0, -1, 0, 0, -1, "after_abort");
  endtask

  task automatic test_random();
    for (int f = 0; f < 24; f++) begin
      run_frame(16'($urandom), 3'($urandom), 1, -1, 0, 1, -1, "random");
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 4; f++) begin
      run_frame(16'($urandom), 3'(3 + f), 0, -1, 0, 0, -1, "b2b");
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_impulse_k3();
    test_ones_k3();
    test_impulse_k6();
    test_backpressure();
    test_clamp_busy();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
